// File: rtl/instr_encoder_writer.sv
// Encodes symbolic instructions into 32-bit words and writes them into imem from a base address.
// Optional build macro ENC_ZERO_REG_GUARD_EN drops instructions that target $0 and pulses o_err.
module instr_encoder_writer #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DEPTH  = 4
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic [ADDR_W-1:0] i_base_addr,
    input  logic              i_in_valid,
    output logic              o_in_ready,
    input  logic              i_in_last,
    input  logic [2:0]        i_in_class,
    input  logic [4:0]        i_in_rs,
    input  logic [4:0]        i_in_rt,
    input  logic [4:0]        i_in_rd,
    input  logic [5:0]        i_in_funct,
    input  logic [15:0]       i_in_imm,
    input  logic [25:0]       i_in_target,
    input  logic              i_mem_busy,
    output logic              o_mem_we,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [31:0]       o_mem_wdata,
    output logic              o_done,
    output logic              o_err
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    logic [1:0]        r_state;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_fifo [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;

    logic [5:0]  w_op;
    logic [31:0] w_word;
    logic        w_reject;
    logic        w_in_ready;
    logic        w_xfer;
    logic        w_push;
    logic        w_pop;

    always_comb begin
        w_op = 6'b000000;
        case (i_in_class)
            3'd0:    w_op = 6'b000000;
            3'd1:    w_op = 6'b000001;
            3'd2:    w_op = 6'b100010;
            3'd3:    w_op = 6'b100011;
            3'd4:    w_op = 6'b101010;
            3'd5:    w_op = 6'b000100;
            3'd6:    w_op = 6'b000110;
            default: w_op = 6'b000010;
        endcase
    end

    always_comb begin
        w_word = {w_op, i_in_rs, i_in_rt, i_in_imm};
        if (i_in_class == 3'd0) begin
            w_word = {w_op, i_in_rs, i_in_rt, i_in_rd, 5'b00000, i_in_funct};
        end else if (i_in_class == 3'd7) begin
            w_word = {w_op, i_in_target};
        end
    end

`ifdef ENC_ZERO_REG_GUARD_EN
    assign w_reject = ((i_in_class == 3'd0) && (i_in_rd == 5'd0)) ||
                      ((i_in_class >= 3'd1) && (i_in_class <= 3'd3) && (i_in_rt == 5'd0));
`else
    assign w_reject = 1'b0;
`endif

    // Ready uses the registered count only: a same-cycle pop never frees a slot for a push.
    assign w_in_ready = (r_state == ST_RUN) && (r_count != CNT_W'(DEPTH));
    assign w_xfer     = i_in_valid & w_in_ready;
    assign w_push     = w_xfer & ~w_reject;
    assign w_pop      = (r_state != ST_IDLE) && (r_count != '0) && ~i_mem_busy;

    assign o_in_ready  = w_in_ready;
    assign o_mem_we    = w_pop;
    assign o_mem_addr  = r_addr;
    assign o_mem_wdata = r_fifo[r_rd_ptr];
    assign o_done      = (r_state == ST_DRAIN) && (r_count == '0);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state  <= ST_IDLE;
            r_addr   <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_fifo[i] <= '0;
            end
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        r_addr  <= i_base_addr;
                        r_state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (w_xfer && i_in_last) begin
                        r_state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (r_count == '0) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase

            if (w_push) begin
                r_fifo[r_wr_ptr] <= w_word;
                r_wr_ptr         <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
                r_addr   <= r_addr + ADDR_W'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CNT_W'(1);
            end else if (!w_push && w_pop) begin
                r_count <= r_count - CNT_W'(1);
            end
        end
    end

`ifdef ENC_ZERO_REG_GUARD_EN
    logic r_err;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_err <= 1'b0;
        end else begin
            r_err <= w_xfer & w_reject;
        end
    end

    assign o_err = r_err;
`else
    assign o_err = 1'b0;
`endif

endmodule

// File: tb/tb_instr_encoder_writer.sv
// Scoreboard bench for instr_encoder_writer: directed cases plus randomized programs.
module tb_instr_encoder_writer;

    logic        clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_start = 1'b0;
    logic [7:0]  i_base_addr = '0;
    logic        i_in_valid = 1'b0;
    logic        o_in_ready;
    logic        i_in_last = 1'b0;
    logic [2:0]  i_in_class = '0;
    logic [4:0]  i_in_rs = '0;
    logic [4:0]  i_in_rt = '0;
    logic [4:0]  i_in_rd = '0;
    logic [5:0]  i_in_funct = '0;
    logic [15:0] i_in_imm = '0;
    logic [25:0] i_in_target = '0;
    logic        w_mem_busy;
    logic        o_mem_we;
    logic [7:0]  o_mem_addr;
    logic [31:0] o_mem_wdata;
    logic        o_done;
    logic        o_err;

    logic busy_hold = 1'b0;
    logic rnd_busy  = 1'b0;
    logic busy_rand = 1'b0;
    assign w_mem_busy = busy_hold | (rnd_busy & busy_rand);

    int checks = 0;
    int errors = 0;
    logic [7:0]  exp_addr [$];
    logic [31:0] exp_data [$];
    logic [7:0]  m_addr = '0;
`ifdef ENC_ZERO_REG_GUARD_EN
    bit guard = 1'b1;
`else
    bit guard = 1'b0;
`endif

    always #5 clk = ~clk;

    initial begin
        forever begin
            @(posedge clk);
            #1 busy_rand = ($urandom_range(0, 2) == 0);
        end
    end

    instr_encoder_writer #(.ADDR_W(8), .DEPTH(4)) dut (
        .i_clk(clk), .i_rst(i_rst), .i_start(i_start), .i_base_addr(i_base_addr),
        .i_in_valid(i_in_valid), .o_in_ready(o_in_ready), .i_in_last(i_in_last),
        .i_in_class(i_in_class), .i_in_rs(i_in_rs), .i_in_rt(i_in_rt), .i_in_rd(i_in_rd),
        .i_in_funct(i_in_funct), .i_in_imm(i_in_imm), .i_in_target(i_in_target),
        .i_mem_busy(w_mem_busy), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr),
        .o_mem_wdata(o_mem_wdata), .o_done(o_done), .o_err(o_err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Reference encoding from the opcode table with plain arithmetic.
    function automatic logic [31:0] ref_word(input int cls, input int rs, input int rt,
                                             input int rd, input int funct, input int imm,
                                             input int tgt);
        int unsigned op_tab [8];
        int unsigned op;
        op_tab = '{0, 1, 34, 35, 42, 4, 6, 2};
        op = op_tab[cls] * 32'd67108864;
        if (cls == 0) return 32'(op + rs * 2097152 + rt * 65536 + rd * 2048 + funct);
        if (cls == 7) return 32'(op + tgt);
        return 32'(op + rs * 2097152 + rt * 65536 + imm);
    endfunction

    function automatic bit rejected(input int cls, input int rt, input int rd);
        return guard && ((cls == 0 && rd == 0) || (cls >= 1 && cls <= 3 && rt == 0));
    endfunction

    logic [7:0]  mon_a;
    logic [31:0] mon_d;
    always @(negedge clk) begin
        if (!i_rst && o_mem_we) begin
            if (exp_data.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: addr %h data %h, expected no write",
                         o_mem_addr, o_mem_wdata);
            end else begin
                mon_a = exp_addr.pop_front();
                mon_d = exp_data.pop_front();
                check("wr_addr", 32'(o_mem_addr), 32'(mon_a));
                check("wr_data", o_mem_wdata, mon_d);
            end
        end
    end

    task automatic do_reset();
        i_rst = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        i_rst = 1'b0;
        exp_addr.delete();
        exp_data.delete();
    endtask

    task automatic start_prog(input logic [7:0] base);
        i_base_addr = base;
        i_start     = 1'b1;
        m_addr      = base;
        @(posedge clk); #1;
        i_start = 1'b0;
        @(negedge clk);
        check("run_ready", 32'(o_in_ready), 32'd1);
        @(posedge clk); #1;
    endtask

    task automatic expect_word(input int cls, input int rs, input int rt, input int rd,
                               input int funct, input int imm, input int tgt);
        exp_addr.push_back(m_addr);
        exp_data.push_back(ref_word(cls, rs, rt, rd, funct, imm, tgt));
        m_addr = m_addr + 8'd1;
    endtask

    task automatic drive(input int cls, input int rs, input int rt, input int rd,
                         input int funct, input int imm, input int tgt, input bit last);
        i_in_class  = 3'(cls);
        i_in_rs     = 5'(rs);
        i_in_rt     = 5'(rt);
        i_in_rd     = 5'(rd);
        i_in_funct  = 6'(funct);
        i_in_imm    = 16'(imm);
        i_in_target = 26'(tgt);
        i_in_last   = last;
        i_in_valid  = 1'b1;
    endtask

    task automatic send(input int cls, input int rs, input int rt, input int rd,
                        input int funct, input int imm, input int tgt, input bit last);
        bit ok = 1'b0;
        bit rej;
        drive(cls, rs, rt, rd, funct, imm, tgt, last);
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (o_in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: got no in_ready, expected handshake");
            i_in_valid = 1'b0;
            @(posedge clk); #1;
            return;
        end
        rej = rejected(cls, rt, rd);
        if (!rej) expect_word(cls, rs, rt, rd, funct, imm, tgt);
        @(posedge clk); #1;
        i_in_valid = 1'b0;
        i_in_last  = 1'b0;
        @(negedge clk);
        check("err_pulse", 32'(o_err), 32'(rej));
        @(posedge clk); #1;
    endtask

    task automatic wait_done();
        bit ok = 1'b0;
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            if (o_done) begin
                ok = 1'b1;
                break;
            end
        end
        check("done_seen", 32'(ok), 32'd1);
        if (ok) begin
            check("drained_at_done", 32'(exp_data.size()), 32'd0);
            @(posedge clk); #1;
            @(negedge clk);
            check("done_one_cycle", 32'(o_done), 32'd0);
            check("idle_not_ready", 32'(o_in_ready), 32'd0);
        end
        @(posedge clk); #1;
    endtask

    int acc;
    int tg [6];
    int n;

    initial begin
        @(posedge clk); #1;
        @(negedge clk);
        check("rst_ready", 32'(o_in_ready), 32'd0);
        check("rst_we", 32'(o_mem_we), 32'd0);
        check("rst_done", 32'(o_done), 32'd0);
        check("rst_err", 32'(o_err), 32'd0);
        check("rst_addr", 32'(o_mem_addr), 32'd0);
        check("rst_wdata", o_mem_wdata, 32'd0);
        do_reset();

        // R-type single-instruction program
        start_prog(8'h10);
        send(0, 1, 2, 3, 6'h20, 0, 0, 1'b1);
        wait_done();

        start_prog(8'h20);
        send(2, 4, 5, 0, 0, 16'h0008, 0, 1'b0);
        send(5, 1, 2, 0, 0, 16'hFFFF, 0, 1'b1);
        wait_done();

        // Address wrap past 0xFF
        start_prog(8'hFF);
        send(7, 0, 0, 0, 0, 0, 26'h0000100, 1'b0);
        send(4, 3, 9, 0, 0, 16'h0040, 0, 1'b1);
        wait_done();

        // Backpressure: FIFO fills at DEPTH while imem is busy
        for (int i = 0; i < 6; i++) tg[i] = int'($urandom_range(0, 26'h3FFFFFF));
        start_prog(8'h50);
        busy_hold = 1'b1;
        acc = 0;
        for (int c = 0; c < 10; c++) begin
            drive(7, 0, 0, 0, 0, 0, tg[acc], 1'b0);
            @(negedge clk);
            if (o_in_ready) begin
                expect_word(7, 0, 0, 0, 0, 0, tg[acc]);
                acc++;
            end
            @(posedge clk); #1;
        end
        i_in_valid = 1'b0;
        @(negedge clk);
        check("full_accepted", 32'(acc), 32'd4);
        check("full_not_ready", 32'(o_in_ready), 32'd0);
        @(posedge clk); #1;
        busy_hold = 1'b0;
        for (int i = acc; i < 6; i++) send(7, 0, 0, 0, 0, 0, tg[i], i == 5);
        wait_done();

        // Reset in DRAIN with three words queued
        start_prog(8'h40);
        busy_hold = 1'b1;
        send(7, 0, 0, 0, 0, 0, 11, 1'b0);
        send(7, 0, 0, 0, 0, 0, 22, 1'b0);
        send(7, 0, 0, 0, 0, 0, 33, 1'b1);
        i_rst = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        check("midrst_we", 32'(o_mem_we), 32'd0);
        check("midrst_ready", 32'(o_in_ready), 32'd0);
        check("midrst_done", 32'(o_done), 32'd0);
        @(posedge clk); #1;
        i_rst = 1'b0;
        busy_hold = 1'b0;
        exp_addr.delete();
        exp_data.delete();
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("post_rst_idle_done", 32'(o_done), 32'd0);
        end
        @(posedge clk); #1;

        // LI with rt=0: rejected only in the guard build
        start_prog(8'h30);
        send(3, 0, 0, 0, 0, 16'h1234, 0, 1'b1);
        wait_done();

        // Randomized programs with random imem stalls
        rnd_busy = 1'b1;
        for (int p = 0; p < 8; p++) begin
            start_prog(8'($urandom_range(0, 255)));
            n = int'($urandom_range(2, 9));
            for (int i = 0; i < n; i++) begin
                repeat ($urandom_range(0, 2)) begin
                    @(posedge clk); #1;
                end
                send(int'($urandom_range(0, 7)), int'($urandom_range(0, 31)),
                     int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
                     int'($urandom_range(0, 63)), int'($urandom_range(0, 16'hFFFF)),
                     int'($urandom_range(0, 26'h3FFFFFF)), i == n - 1);
            end
            wait_done();
        end
        rnd_busy = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
